// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch controller and imem.
interface fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;

    modport master (output imem_req, output imem_addr, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the imem handshake and the IF/ID
// write-enable/flush, applying redirects and stalls with fixed priority.
module fetch_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       MAX_WAIT = 15,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mem_pcsrc,
    input  logic [ADDR_W-1:0] ex_mem_npc,
    input  logic              id_stall,
    fetch_ctrl_if.master      imem,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              misalign,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT,
        S_CANCEL,
        S_ERROR
    } state_t;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [ADDR_W-1:0]   pc_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                timeout_nxt;
    logic                req;
    logic                redirect;
    logic                accept;

    assign npc            = pc + ADDR_W'(4);
    assign imem.imem_addr = pc;
    assign imem.imem_req  = req;

    // State register and architectural state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            wait_cnt    <= '0;
            fetch_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            wait_cnt    <= wait_nxt;
            fetch_cnt   <= cnt_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    // Next-state and handshake outputs; redirect overrides everything below it
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        pc_nxt      = pc;
        cnt_nxt     = fetch_cnt;
        timeout_nxt = timeout_err;
        req         = 1'b0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
        misalign    = 1'b0;
        redirect    = 1'b0;
        accept      = 1'b0;

        case (state)
            S_BOOT: state_nxt = S_FETCH;
            S_FETCH: begin
                req = 1'b1;
                if (!imem.imem_ready) begin
                    state_nxt = S_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (imem.imem_ready) begin
                    state_nxt = S_FETCH;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    state_nxt   = S_ERROR;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_CANCEL: state_nxt = S_FETCH;
            S_ERROR:  if_id_flush = rst_n;
            default:  state_nxt = S_BOOT;
        endcase

        accept = rst_n & req & imem.imem_ready & ~id_stall & ~ex_mem_pcsrc;
        if (accept) begin
            if_id_we = 1'b1;
            pc_nxt   = npc;
            cnt_nxt  = fetch_cnt + CNT_W'(1);
        end

        redirect = rst_n & ex_mem_pcsrc & (state != S_ERROR);
        if (redirect) begin
            if_id_flush = 1'b1;
            if_id_we    = 1'b0;
            misalign    = |ex_mem_npc[1:0];
            pc_nxt      = {ex_mem_npc[ADDR_W-1:2], 2'b00};
            wait_nxt    = '0;
            // An abandoned in-flight request needs one idle cycle before refetch
            state_nxt   = (state == S_WAIT || state == S_CANCEL) ? S_CANCEL : S_FETCH;
        end

        if (!rst_n) begin
            req = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed stimulus, accepted fetch addresses checked
// against a scoreboard queue as if_id_we fires.
module tb_fetch_ctrl;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned MAX_WAIT = 15;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ex_mem_pcsrc;
    logic [ADDR_W-1:0] ex_mem_npc;
    logic              id_stall;
    logic [ADDR_W-1:0] pc, npc;
    logic              if_id_we, if_id_flush, misalign, timeout_err;
    logic [CNT_W-1:0]  fetch_cnt;

    fetch_ctrl_if #(.ADDR_W(ADDR_W)) imem_if ();

    fetch_ctrl #(
        .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_pcsrc(ex_mem_pcsrc), .ex_mem_npc(ex_mem_npc), .id_stall(id_stall),
        .imem(imem_if),
        .pc(pc), .npc(npc), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .misalign(misalign), .timeout_err(timeout_err), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Every accepted instruction must match the oldest expected fetch address
    always @(negedge clk) begin
        if (rst_n && if_id_we === 1'b1) begin
            if (exp_q.size() == 0)
                check_eq("unexpected_accept", 64'(imem_if.imem_addr), 64'hDEAD);
            else
                check_eq("accept_addr", 64'(imem_if.imem_addr), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        ex_mem_pcsrc       = 1'b0;
        ex_mem_npc         = '0;
        id_stall           = 1'b0;
        imem_if.imem_ready = 1'b1;

        at_neg();
        check_eq("rst_pc", 64'(pc), 64'(RESET_PC));
        check_eq("rst_req", 64'(imem_if.imem_req), 64'd0);
        check_eq("rst_we", 64'(if_id_we), 64'd0);
        check_eq("rst_flush", 64'(if_id_flush), 64'd0);
        check_eq("rst_timeout", 64'(timeout_err), 64'd0);
        check_eq("rst_cnt", 64'(fetch_cnt), 64'd0);

        tick();
        rst_n = 1'b1;
        at_neg();
        check_eq("boot_req", 64'(imem_if.imem_req), 64'd0);
        check_eq("boot_we", 64'(if_id_we), 64'd0);
        tick();

        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ADDR_W'(4 * i));
            at_neg();
            check_eq("seq_pc", 64'(pc), 64'(4 * i));
            check_eq("seq_npc", 64'(npc), 64'(4 * i + 4));
            check_eq("seq_we", 64'(if_id_we), 64'd1);
            tick();
        end

        id_stall = 1'b1;
        at_neg();
        check_eq("cnt_after4", 64'(fetch_cnt), 64'd4);
        check_eq("stall_pc", 64'(pc), 64'h10);
        check_eq("stall_we", 64'(if_id_we), 64'd0);
        check_eq("stall_req", 64'(imem_if.imem_req), 64'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            at_neg();
            check_eq("stall_pc", 64'(pc), 64'h10);
            check_eq("stall_we", 64'(if_id_we), 64'd0);
        end
        tick();
        id_stall = 1'b0;
        exp_q.push_back(ADDR_W'(32'h10));
        at_neg();
        check_eq("unstall_we", 64'(if_id_we), 64'd1);

        tick();
        ex_mem_pcsrc = 1'b1;
        ex_mem_npc   = 32'h40;
        at_neg();
        check_eq("redir_pc", 64'(pc), 64'h14);
        check_eq("redir_flush", 64'(if_id_flush), 64'd1);
        check_eq("redir_we", 64'(if_id_we), 64'd0);
        check_eq("redir_misalign", 64'(misalign), 64'd0);
        tick();
        ex_mem_npc = 32'h42;
        at_neg();
        check_eq("redir_target", 64'(pc), 64'h40);
        check_eq("misalign_pulse", 64'(misalign), 64'd1);
        check_eq("misalign_flush", 64'(if_id_flush), 64'd1);
        tick();
        ex_mem_pcsrc       = 1'b0;
        imem_if.imem_ready = 1'b0;
        at_neg();
        check_eq("aligned_pc", 64'(pc), 64'h40);
        check_eq("misalign_clear", 64'(misalign), 64'd0);
        check_eq("notready_we", 64'(if_id_we), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            at_neg();
            check_eq("wait_addr", 64'(imem_if.imem_addr), 64'h40);
            check_eq("wait_req", 64'(imem_if.imem_req), 64'd1);
        end
        tick();
        imem_if.imem_ready = 1'b1;
        exp_q.push_back(ADDR_W'(32'h40));
        at_neg();
        check_eq("wait_accept_we", 64'(if_id_we), 64'd1);

        tick();
        imem_if.imem_ready = 1'b0;
        at_neg();
        check_eq("post_wait_pc", 64'(pc), 64'h44);
        tick();
        ex_mem_pcsrc = 1'b1;
        ex_mem_npc   = 32'h100;
        at_neg();
        check_eq("wait_redir_flush", 64'(if_id_flush), 64'd1);
        check_eq("wait_redir_req", 64'(imem_if.imem_req), 64'd1);
        tick();
        ex_mem_pcsrc       = 1'b0;
        imem_if.imem_ready = 1'b1;
        at_neg();
        check_eq("cancel_req", 64'(imem_if.imem_req), 64'd0);
        check_eq("cancel_we", 64'(if_id_we), 64'd0);
        check_eq("cancel_pc", 64'(pc), 64'h100);
        tick();
        exp_q.push_back(ADDR_W'(32'h100));
        at_neg();
        check_eq("refetch_addr", 64'(imem_if.imem_addr), 64'h100);
        check_eq("refetch_we", 64'(if_id_we), 64'd1);

        tick();
        imem_if.imem_ready = 1'b0;
        at_neg();
        check_eq("to_pc", 64'(pc), 64'h104);
        for (int i = 0; i < int'(MAX_WAIT); i++) begin
            tick();
            at_neg();
            check_eq("to_wait_req", 64'(imem_if.imem_req), 64'd1);
            check_eq("to_wait_err", 64'(timeout_err), 64'd0);
        end
        tick();
        at_neg();
        check_eq("timeout_err", 64'(timeout_err), 64'd1);
        check_eq("err_req", 64'(imem_if.imem_req), 64'd0);
        check_eq("err_flush", 64'(if_id_flush), 64'd1);
        check_eq("err_we", 64'(if_id_we), 64'd0);
        tick();
        ex_mem_pcsrc       = 1'b1;
        ex_mem_npc         = 32'h202;
        imem_if.imem_ready = 1'b1;
        at_neg();
        check_eq("err_misalign", 64'(misalign), 64'd0);
        check_eq("err_we_ready", 64'(if_id_we), 64'd0);
        tick();
        at_neg();
        check_eq("err_pc_frozen", 64'(pc), 64'h104);
        check_eq("err_sticky", 64'(timeout_err), 64'd1);

        rst_n = 1'b0;
        #1;
        check_eq("rerst_pc", 64'(pc), 64'(RESET_PC));
        check_eq("rerst_timeout", 64'(timeout_err), 64'd0);
        check_eq("rerst_cnt", 64'(fetch_cnt), 64'd0);
        check_eq("rerst_flush", 64'(if_id_flush), 64'd0);
        check_eq("rerst_req", 64'(imem_if.imem_req), 64'd0);

        tick();
        rst_n        = 1'b1;
        ex_mem_npc   = 32'hFFFF_FFFC;
        at_neg();
        check_eq("boot_redir_req", 64'(imem_if.imem_req), 64'd0);
        check_eq("boot_redir_flush", 64'(if_id_flush), 64'd1);
        tick();
        ex_mem_pcsrc = 1'b0;
        exp_q.push_back(ADDR_W'(32'hFFFF_FFFC));
        at_neg();
        check_eq("wrap_pc", 64'(pc), 64'hFFFF_FFFC);
        check_eq("wrap_npc", 64'(npc), 64'h0);
        tick();
        id_stall = 1'b1;
        at_neg();
        check_eq("wrapped_pc", 64'(pc), 64'h0);
        check_eq("wrap_cnt", 64'(fetch_cnt), 64'd1);
        tick();

        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
